disco_dma: RTL



---
 rtl/disco_pkg.sv | 20 ++
 rtl/disco_dma_counter.sv | 38 +++
 rtl/disco_dma.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/disco_pkg.sv
// Shared constants for the disk/memory block-transfer engine.
// Holds the FSM state encoding, transfer direction codes and default widths.
package disco_pkg;

  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_DISK_ADDR_WIDTH = 15;
  localparam int DEF_MEM_ADDR_WIDTH  = 10;
  localparam int DEF_LEN_WIDTH       = 16;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/disco_dma_counter.sv
// Loadable address/remaining-length counter; address wraps modulo 2^AW.
// Latency: load/step take effect at the next edge. No backpressure: steps whenever en=1.
module disco_dma_counter
  import disco_pkg::*;
#(
  parameter int AW = DEF_DISK_ADDR_WIDTH,
  parameter int LW = DEF_LEN_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic [LW-1:0] len_i,
  input  logic          en_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      rem_q  <= len_i;
    end else if (en_i) begin
      addr_q <= addr_q + AW'(1);
      rem_q  <= rem_q - LW'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == LW'(1));

endmodule

// File: rtl/disco_dma.sv
// Disk<->memory block copier: LOAD one word/cycle, STORE pipelined behind the 1-cycle memory read.
// Latency: done 1 cycle after the last write. No backpressure. Option: DISCO_DMA_CHECKSUM_EN adds csum.
module disco_dma
  import disco_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DISK_ADDR_WIDTH = DEF_DISK_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH  = DEF_MEM_ADDR_WIDTH,
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       dir,
  input  logic [DISK_ADDR_WIDTH-1:0] disk_base,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_base,
  input  logic [LEN_WIDTH-1:0]       len,
  output logic                       busy,
  output logic                       done,
  output logic [DISK_ADDR_WIDTH-1:0] disk_addr,
  output logic [DATA_WIDTH-1:0]      disk_data,
  output logic                       disk_tr,
  input  logic [DATA_WIDTH-1:0]      disk_q,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_we,
  input  logic [DATA_WIDTH-1:0]      mem_q
`ifdef DISCO_DMA_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]      csum
`endif
);

  state_e state_q, state_d;
  logic   mem_we_q, mem_we_d;
  logic   disk_tr_q, disk_tr_d;
  logic   rd_act_q, rd_act_d;
  logic   accept, mem_en, disk_en, mem_last, disk_last;

  assign accept  = (state_q == S_IDLE) && start;
  // STORE: memory side steps while reads issue, disk side steps one cycle later on each write.
  assign mem_en  = mem_we_q | rd_act_q;
  assign disk_en = mem_we_q | disk_tr_q;

  disco_dma_counter #(.AW(DISK_ADDR_WIDTH), .LW(LEN_WIDTH)) u_disk_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .base_i (disk_base),
    .len_i  (len),
    .en_i   (disk_en),
    .addr_o (disk_addr),
    .last_o (disk_last)
  );

  disco_dma_counter #(.AW(MEM_ADDR_WIDTH), .LW(LEN_WIDTH)) u_mem_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .base_i (mem_base),
    .len_i  (len),
    .en_i   (mem_en),
    .addr_o (mem_addr),
    .last_o (mem_last)
  );

  always_comb begin
    state_d   = state_q;
    mem_we_d  = mem_we_q;
    disk_tr_d = 1'b0;
    rd_act_d  = rd_act_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = S_FIN;
          end else if (dir == DIR_STORE) begin
            state_d  = S_STORE;
            rd_act_d = 1'b1;
          end else begin
            state_d  = S_LOAD;
            mem_we_d = (dir == DIR_LOAD);
          end
        end
      end
      S_LOAD: begin
        if (mem_last) begin
          mem_we_d = 1'b0;
          state_d  = S_FIN;
        end
      end
      S_STORE: begin
        disk_tr_d = rd_act_q;
        if (rd_act_q && mem_last) rd_act_d = 1'b0;
        if (disk_tr_q && disk_last) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_we_q  <= 1'b0;
      disk_tr_q <= 1'b0;
      rd_act_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_we_q  <= mem_we_d;
      disk_tr_q <= disk_tr_d;
      rd_act_q  <= rd_act_d;
    end
  end

  assign busy      = (state_q == S_LOAD) || (state_q == S_STORE);
  assign done      = (state_q == S_FIN);
  assign mem_we    = mem_we_q;
  assign disk_tr   = disk_tr_q;
  assign mem_data  = disk_q;
  assign disk_data = mem_q;

`ifdef DISCO_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (mem_we_q) begin
      csum_q <= csum_q + disk_q;
    end else if (disk_tr_q) begin
      csum_q <= csum_q + mem_q;
    end
  end

  assign csum = csum_q;
`endif

endmodule
